dmem_responder: RTL and testbench
=================================

# dmem_responder

Responder side of the pipeline's data-memory interface. It accepts one load or store request at a time from the M stage and holds the pipeline stalled while the access runs for a programmable number of wait states. It then returns read data, or commits byte-enabled write data, together with a one-cycle completion pulse. It replaces the zero-latency data memory so the pipeline's stall path is exercised against a realistic slow memory.

## Interface
- ADDR_W, 10 — word-address bits; capacity 2^ADDR_W 32-bit words.
- LATENCY, 2 — wait-state count, legal 0..15.
- clk  input  1  — sole clock, rising edge.
- rst_n  input  1  — asynchronous, active-low reset.
- req_valid  input  1  — M-stage request (MemRead | MemWrite); held stable until the cycle after resp_ready.
- req_we  input  1  — 1 = store, 0 = load.
- req_addr  input  32  — byte address; bits [1:0] ignored.
- req_wdata  input  32  — store data.
- req_be  input  4  — byte enables for stores; bit i selects wdata[8i+7:8i].
- stall  output  1  — holds PC, IF/ID and downstream registers.
- resp_ready  output  1  — one-cycle completion pulse.
- resp_rdata  output  32  — load data, valid while resp_ready = 1; holds its value afterwards.
- resp_err  output  1  — out-of-range access flag, valid with resp_ready.
- mmio_out  output  32  — MMIO output register (see Configuration).

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid, latch we/addr/wdata/be, load cnt = LATENCY, go to BUSY.
- BUSY:
  - stall = 1.
  - If cnt != 0: cnt decrements.
  - If cnt == 0 at the edge: perform the access and go to DONE.
- The access:
  - Store: memory bytes with be = 1 are written.
  - Load: the addressed word is registered into resp_rdata.
- DONE:
  - stall = 0, resp_ready = 1.
  - Unconditionally returns to IDLE. req_valid is ignored in this cycle, because the pipeline advances at this edge.
- Range check: access is in range iff addr[31:ADDR_W+2] == 0. Out of range:
  - Store suppressed.
  - resp_rdata = 0.
  - resp_err = 1 in DONE.
- Store with be = 4'h0: completes normally, no memory change.
- resp_rdata is unchanged by stores.
- The memory array is not reset.

## Timing
- Request first seen in IDLE at cycle T.
  - Cycles T .. T+LATENCY+1: stall = 1.
  - Cycle T+LATENCY+2: DONE.
- Total stall cycles = LATENCY+2. With LATENCY = 0: one BUSY cycle, DONE at T+2.
- Back-to-back requests: the next request is accepted no earlier than the IDLE cycle after DONE. Minimum request spacing is LATENCY+3 cycles.
- Request inputs are sampled only at the IDLE→BUSY edge. Later changes are ignored until the next acceptance.
- Reset (asynchronous, any state):
  - State = IDLE, cnt = 0.
  - stall = 0 unless req_valid, resp_ready = 0, resp_err = 0, resp_rdata = 0, mmio_out = 0.
  - A pending store in BUSY is abandoned with memory unchanged.
  - A store whose commit edge coincides with rst_n assertion is not committed.

## Configuration
- DMEM_MMIO_EN defined:
  - Word address 0xFFFF_FFF0 maps to the mmio_out register.
  - Stores update it byte-wise per be; loads return it.
  - No resp_err for this address; main memory is untouched.
  - mmio_out changes at the commit edge.
- DMEM_MMIO_EN undefined:
  - mmio_out is tied to 0.
  - 0xFFFF_FFF0 is treated as an ordinary out-of-range address (resp_err = 1).

## Test plan
- Reset then idle: rst_n low mid-BUSY of a store of 0xDEADBEEF to 0x10 with LATENCY = 2.
  - All outputs read 0 during and after reset.
  - A later load of 0x10 returns the pre-reset contents, not 0xDEADBEEF.
- Store/load word, LATENCY = 2: store 0x12345678 to 0x40 (be = 4'hF), then load 0x40.
  - Each access: stall high exactly 4 cycles, resp_ready pulse in cycle 5.
  - Load returns 0x12345678, resp_err = 0.
- Byte enables: after the above, store 0xAABBCCDD to 0x40 with be = 4'b0101, then load 0x40.
  - Load returns 0x12BB56DD.
- LATENCY = 0, back-to-back loads from 0x0 and 0x4 (req_valid held across).
  - Stall cycles = 2 per access.
  - Second request accepted in the IDLE cycle after DONE; resp_ready pulses are 3 cycles apart.
- Out of range, ADDR_W = 10: store to 0x1000, then load 0x1000.
  - Both return resp_err = 1; the load returns resp_rdata = 0.
  - Word 0x0 is unchanged.
- MMIO, built both ways: store 0x000000FF to 0xFFFF_FFF0.
  - With DMEM_MMIO_EN: mmio_out = 0x000000FF at the commit edge; load returns 0xFF; resp_err = 0.
  - Without DMEM_MMIO_EN: mmio_out = 0 and resp_err = 1.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY wait states per access.
// Optional MMIO output register at word address 0xFFFF_FFF0 when DMEM_MMIO_EN is defined.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        stall,
    output logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mmio_out
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] mmio_q;
    logic [31:0] mem [2**ADDR_W];

    logic              in_range;
    logic              is_mmio;
    logic [ADDR_W-1:0] idx;
    logic              addr_lsb_unused;

    assign addr_lsb_unused = ^req_addr[1:0];
    assign in_range        = (addr_q[31:ADDR_W+2] == '0);
    assign idx             = addr_q[ADDR_W+1:2];

`ifdef DMEM_MMIO_EN
    assign is_mmio  = (addr_q == 30'h3FFF_FFFC);
    assign mmio_out = mmio_q;
`else
    assign is_mmio  = 1'b0;
    assign mmio_out = '0;
`endif

    // Combinational in IDLE so the requesting instruction stalls in its own cycle.
    assign stall = (state == IDLE) ? req_valid : (state == BUSY);

    // Memory write sits in the reset-qualified branch so a commit edge that
    // coincides with reset assertion never reaches the array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            mmio_q     <= '0;
            resp_ready <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_ready <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr[31:2];
                        wdata_q <= req_wdata;
                        be_q    <= req_be;
                        cnt     <= 4'(LATENCY);
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state      <= DONE;
                        resp_ready <= 1'b1;
                        resp_err   <= !in_range && !is_mmio;
                        if (!we_q) begin
                            if (is_mmio)
                                resp_rdata <= mmio_q;
                            else if (in_range)
                                resp_rdata <= mem[idx];
                            else
                                resp_rdata <= '0;
                        end else if (is_mmio) begin
                            for (int unsigned b = 0; b < 4; b++)
                                if (be_q[b]) mmio_q[8*b +: 8] <= wdata_q[8*b +: 8];
                        end else if (in_range) begin
                            for (int unsigned b = 0; b < 4; b++)
                                if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance at LATENCY=2, one at LATENCY=0.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_req_valid, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata;
    logic [3:0]  a_req_be;
    logic        a_stall, a_resp_ready, a_resp_err;
    logic [31:0] a_resp_rdata, a_mmio_out;

    logic        b_req_valid, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_be;
    logic        b_stall, b_resp_ready, b_resp_err;
    logic [31:0] b_resp_rdata, b_mmio_out;

    dmem_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(a_req_valid), .req_we(a_req_we), .req_addr(a_req_addr),
        .req_wdata(a_req_wdata), .req_be(a_req_be),
        .stall(a_stall), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .mmio_out(a_mmio_out)
    );

    dmem_responder #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr),
        .req_wdata(b_req_wdata), .req_be(b_req_be),
        .stall(b_stall), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .mmio_out(b_mmio_out)
    );

`ifdef DMEM_MMIO_EN
    localparam logic        MMIO_ERR = 1'b0;
    localparam logic [31:0] MMIO_VAL = 32'h0000_00FF;
`else
    localparam logic        MMIO_ERR = 1'b1;
    localparam logic [31:0] MMIO_VAL = 32'h0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Request on the LATENCY=2 instance; inputs are scrambled after acceptance.
    task automatic a_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input logic [31:0] exp_mmio);
        int  stalls = 0;
        int  cyc    = 0;
        bit  done   = 0;
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr;
        a_req_wdata = wdata; a_req_be = be;
        while (!done && cyc < 40) begin
            @(negedge clk);
            if (a_resp_ready) begin
                done = 1;
                check({tag, ".done_cycle"}, 32'(cyc), 32'd4);
                check({tag, ".stall_in_done"}, {31'b0, a_stall}, 32'd0);
                check({tag, ".err"}, {31'b0, a_resp_err}, {31'b0, exp_err});
                check({tag, ".rdata"}, a_resp_rdata, exp_rdata);
                check({tag, ".mmio"}, a_mmio_out, exp_mmio);
            end else if (a_stall) begin
                stalls++;
            end
            cyc++;
            @(posedge clk); #1;
            if (cyc == 1) begin
                a_req_wdata = ~wdata; a_req_be = ~be; a_req_addr = addr ^ 32'h4;
            end
        end
        a_req_valid = 1'b0;
        check({tag, ".completed"}, {31'b0, done}, 32'd1);
        check({tag, ".stall_cycles"}, 32'(stalls), 32'd4);
    endtask

    task automatic b_req(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
        int stalls = 0;
        int cyc    = 0;
        bit done   = 0;
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr;
        b_req_wdata = wdata; b_req_be = 4'hF;
        while (!done && cyc < 20) begin
            @(negedge clk);
            if (b_resp_ready) begin
                done = 1;
                check({tag, ".rdata"}, b_resp_rdata, exp_rdata);
            end else if (b_stall) begin
                stalls++;
            end
            cyc++;
            @(posedge clk); #1;
        end
        b_req_valid = 1'b0;
        check({tag, ".completed"}, {31'b0, done}, 32'd1);
        check({tag, ".stall_cycles"}, 32'(stalls), 32'd2);
    endtask

    initial begin
        int pulses = 0;
        int c = 0;
        int stalls = 0;
        int p1 = 0;

        rst_n = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_addr = 0; a_req_wdata = 0; a_req_be = 0;
        b_req_valid = 0; b_req_we = 0; b_req_addr = 0; b_req_wdata = 0; b_req_be = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.stall", {31'b0, a_stall}, 32'd0);
        check("rst.ready", {31'b0, a_resp_ready}, 32'd0);
        check("rst.err", {31'b0, a_resp_err}, 32'd0);
        check("rst.rdata", a_resp_rdata, 32'd0);
        check("rst.mmio", a_mmio_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        a_req("pre_st", 1'b1, 32'h10, 32'h1111_1111, 4'hF, 32'h0, 1'b0, 32'h0);
        a_req("pre_ld", 1'b0, 32'h10, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 32'h0);

        // Reset lands while the DEADBEEF store is waiting in BUSY.
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
        a_req_wdata = 32'hDEAD_BEEF; a_req_be = 4'hF;
        @(negedge clk);
        check("midrst.accept_stall", {31'b0, a_stall}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        a_req_valid = 1'b0;
        #1;
        check("midrst.stall", {31'b0, a_stall}, 32'd0);
        check("midrst.ready", {31'b0, a_resp_ready}, 32'd0);
        check("midrst.err", {31'b0, a_resp_err}, 32'd0);
        check("midrst.rdata", a_resp_rdata, 32'd0);
        check("midrst.mmio", a_mmio_out, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("postrst.stall", {31'b0, a_stall}, 32'd0);
        check("postrst.ready", {31'b0, a_resp_ready}, 32'd0);
        @(posedge clk); #1;
        a_req("postrst_ld", 1'b0, 32'h10, 32'h0, 4'h0, 32'h1111_1111, 1'b0, 32'h0);

        a_req("w_st", 1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'h1111_1111, 1'b0, 32'h0);
        a_req("w_ld", 1'b0, 32'h40, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 32'h0);
        a_req("be_st", 1'b1, 32'h40, 32'hAABB_CCDD, 4'b0101, 32'h1234_5678, 1'b0, 32'h0);
        a_req("be_ld", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 32'h0);
        a_req("be0_st", 1'b1, 32'h40, 32'hFFFF_FFFF, 4'h0, 32'h12BB_56DD, 1'b0, 32'h0);
        a_req("be0_ld", 1'b0, 32'h40, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0, 32'h0);

        a_req("z_st", 1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 32'h12BB_56DD, 1'b0, 32'h0);
        a_req("oor_st", 1'b1, 32'h1000, 32'hA5A5_A5A5, 4'hF, 32'h12BB_56DD, 1'b1, 32'h0);
        a_req("z_ld", 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 32'h0);
        a_req("oor_ld", 1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 32'h0);

        a_req("mmio_st", 1'b1, 32'hFFFF_FFF0, 32'h0000_00FF, 4'hF, 32'h0, MMIO_ERR, MMIO_VAL);
        a_req("mmio_ld", 1'b0, 32'hFFFF_FFF0, 32'h0, 4'h0, MMIO_VAL, MMIO_ERR, MMIO_VAL);

        b_req("l0_st0", 1'b1, 32'h0, 32'h0000_0111, 32'h0);
        b_req("l0_st4", 1'b1, 32'h4, 32'h0000_0222, 32'h0);

        // Back-to-back loads with req_valid held high across both accesses.
        b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 32'h0;
        while (pulses < 2 && c < 20) begin
            @(negedge clk);
            if (b_resp_ready) begin
                pulses++;
                if (pulses == 1) begin
                    p1 = c;
                    check("b2b.rdata0", b_resp_rdata, 32'h0000_0111);
                end else begin
                    check("b2b.spacing", 32'(c - p1), 32'd3);
                    check("b2b.rdata4", b_resp_rdata, 32'h0000_0222);
                end
            end else if (b_stall) begin
                stalls++;
            end
            c++;
            @(posedge clk); #1;
            if (pulses == 1) b_req_addr = 32'h4;
        end
        b_req_valid = 1'b0;
        check("b2b.pulses", 32'(pulses), 32'd2);
        check("b2b.first_done", 32'(p1), 32'd2);
        check("b2b.stall_cycles", 32'(stalls), 32'd4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
